// File: rtl/fix_ari_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fix_ari_mul_seq
//  Description : Sequential sign-magnitude fixed-point multiplier. One
//                multiplier bit per cycle (shift-and-add), followed by a
//                rounding/saturation step and a valid/ready result hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module fix_ari_mul_seq #(
  parameter  int INTE = 7,
  parameter  int POIN = 8,
  parameter  int SAT  = 1,
  localparam int M    = INTE + POIN,
  localparam int DATA = 1 + M
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA-1:0]   data_in1,
  input  logic [DATA-1:0]   data_in2,
  input  logic              round_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*M:0]      data_out,
  output logic [DATA-1:0]   data_out_round,
  output logic              ovf
);

  localparam int              CW   = $clog2(M);
  localparam logic [CW-1:0]   LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RND  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nx;

  logic [DATA-1:0]     op_a;
  logic [DATA-1:0]     op_b;
  logic                rm;
  logic [2*M-1:0]      acc;
  logic [CW-1:0]       cnt;

  logic [2*M-1:0]      addend;
  logic                round_bit;
  logic [2*M:0]        r;
  logic                ovf_c;
  logic [M-1:0]        mag_rnd;
  logic                sign;
  logic [2*M:0]        full_c;
  logic [DATA-1:0]     rnd_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; in_valid only matters in IDLE, out_ready only in DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)       state_nx = BUSY;
      BUSY:    if (cnt == LAST)    state_nx = RND;
      RND:                         state_nx = DONE;
      DONE:    if (out_ready)      state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Partial product, rounding and saturation of the finished accumulator
  always_comb begin
    addend    = {{M{1'b0}}, op_a[M-1:0]} << cnt;
    round_bit = rm & acc[POIN-1];
    r         = {1'b0, acc >> POIN} + {{(2*M){1'b0}}, round_bit};
    ovf_c     = |r[2*M:M];
    mag_rnd   = (ovf_c && (SAT != 0)) ? {M{1'b1}} : r[M-1:0];
    sign      = op_a[DATA-1] ^ op_b[DATA-1];
    // A zero magnitude never carries a negative sign
    full_c    = {sign & (|acc), acc};
    rnd_c     = {sign & (|mag_rnd), mag_rnd};
  end

  // Operand capture, shift-and-add accumulation and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a           <= '0;
      op_b           <= '0;
      rm             <= 1'b0;
      acc            <= '0;
      cnt            <= '0;
      data_out       <= '0;
      data_out_round <= '0;
      ovf            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a <= data_in1;
            op_b <= data_in2;
            rm   <= round_mode;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        BUSY: begin
          if (op_b[cnt]) acc <= acc + addend;
          cnt <= cnt + 1'b1;
        end
        RND: begin
          data_out       <= full_c;
          data_out_round <= rnd_c;
          ovf            <= ovf_c;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fix_ari_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fix_ari_mul_seq
//  Description : Self-checking bench for fix_ari_mul_seq; a SAT=1 and a SAT=0
//                instance share stimulus and are compared to an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fix_ari_mul_seq;

  localparam int INTE = 7;
  localparam int POIN = 8;
  localparam int M    = INTE + POIN;
  localparam int DATA = 1 + M;
  localparam int OW   = 2 * M + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            round_mode;
  logic            out_ready;
  logic [DATA-1:0] data_in1;
  logic [DATA-1:0] data_in2;

  logic            in_ready,   in_ready_w;
  logic            out_valid,  out_valid_w;
  logic [OW-1:0]   data_out,   data_out_w;
  logic [DATA-1:0] data_out_round, data_out_round_w;
  logic            ovf,        ovf_w;

  int checks = 0;
  int errors = 0;

  fix_ari_mul_seq #(.INTE(INTE), .POIN(POIN), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in1(data_in1), .data_in2(data_in2), .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .data_out_round(data_out_round), .ovf(ovf)
  );

  fix_ari_mul_seq #(.INTE(INTE), .POIN(POIN), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .data_in1(data_in1), .data_in2(data_in2), .round_mode(round_mode),
    .out_valid(out_valid_w), .out_ready(out_ready), .data_out(data_out_w),
    .data_out_round(data_out_round_w), .ovf(ovf_w)
  );

  always #5 clk = ~clk;

  // Reference: integer product of magnitudes, then round/saturate arithmetically
  task automatic model(input logic [DATA-1:0] a, input logic [DATA-1:0] b,
                       input logic rmode, input int sat,
                       output logic [OW-1:0] full, output logic [DATA-1:0] rnd,
                       output logic ov);
    longint ma, mb, p, r, lim, mag;
    logic   s;
    ma  = longint'(a[M-1:0]);
    mb  = longint'(b[M-1:0]);
    s   = a[DATA-1] ^ b[DATA-1];
    p   = ma * mb;
    lim = longint'(1) << M;
    r   = (p >> POIN) + (rmode ? ((p >> (POIN - 1)) & 1) : 0);
    ov  = (r >= lim);
    mag = ov ? ((sat != 0) ? lim - 1 : r % lim) : r;
    full[OW-1]     = s && (p != 0);
    full[OW-2:0]   = p[2*M-1:0];
    rnd[DATA-1]    = s && (mag != 0);
    rnd[M-1:0]     = mag[M-1:0];
  endtask

  // One transaction; returns at the first DONE sample with out_ready=1 driven.
  // noise keeps in_valid high with changing operands while the block is busy.
  task automatic run_op(input logic [DATA-1:0] a, input logic [DATA-1:0] b,
                        input logic rmode, input int stall, input bit noise);
    logic [OW-1:0]   ef, ef0;
    logic [DATA-1:0] er1, er0;
    logic            eo1, eo0;
    int              cyc;
    model(a, b, rmode, 1, ef, er1, eo1);
    model(a, b, rmode, 0, ef0, er0, eo0);
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_idle: got %b want 1", in_ready);
    end
    in_valid   = 1'b1;
    data_in1   = a;
    data_in2   = b;
    round_mode = rmode;
    out_ready  = 1'b1;
    @(negedge clk);
    if (!noise) in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      if (noise) begin
        data_in1   = DATA'($urandom);
        data_in2   = DATA'($urandom);
        round_mode = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc != M + 1) begin
      errors++;
      $display("FAIL latency a=%h b=%h: got %0d want %0d", a, b, cyc, M + 1);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_ready_done: got %b want 0", in_ready);
    end
    checks++;
    if (data_out !== ef) begin
      errors++;
      $display("FAIL data_out a=%h b=%h rm=%b: got %h want %h", a, b, rmode, data_out, ef);
    end
    checks++;
    if (data_out_round !== er1 || ovf !== eo1) begin
      errors++;
      $display("FAIL round_sat a=%h b=%h rm=%b: got %h/%b want %h/%b",
               a, b, rmode, data_out_round, ovf, er1, eo1);
    end
    checks++;
    if (data_out_round_w !== er0 || ovf_w !== eo0 || out_valid_w !== 1'b1) begin
      errors++;
      $display("FAIL round_wrap a=%h b=%h rm=%b: got %h/%b/%b want %h/%b/1",
               a, b, rmode, data_out_round_w, ovf_w, out_valid_w, er0, eo0);
    end
    if (stall > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in1  = DATA'($urandom);
      data_in2  = DATA'($urandom);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== ef ||
            data_out_round !== er1 || ovf !== eo1) begin
          errors++;
          $display("FAIL stall_hold cyc %0d: got v=%b rdy=%b %h %h %b want v=1 rdy=0 %h %h %b",
                   i, out_valid, in_ready, data_out, data_out_round, ovf, ef, er1, eo1);
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    round_mode = 1'b0;
    data_in1   = '0;
    data_in2   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== '0 ||
        data_out_round !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b %h %h %b want 1 0 0 0 0",
               in_ready, out_valid, data_out, data_out_round, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(16'h0180, 16'h0200, 1'b0, 0, 1'b0);
    checks++;
    if (data_out !== 31'h0003_0000 || data_out_round !== 16'h0300 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_const: got %h %h %b want 00030000 0300 0", data_out, data_out_round, ovf);
    end
  endtask

  task automatic test_sign();
    run_op(16'h8180, 16'h0200, 1'b0, 0, 1'b0);
    checks++;
    if (data_out_round !== 16'h8300 || data_out[30] !== 1'b1) begin
      errors++;
      $display("FAIL sign_neg: got %h sign %b want 8300 sign 1", data_out_round, data_out[30]);
    end
    run_op(16'h8000, 16'h0005, 1'b0, 0, 1'b0);
    checks++;
    if (data_out_round !== 16'h0000 || data_out !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL neg_zero: got %h %h %b want 0000 0 0", data_out_round, data_out, ovf);
    end
  endtask

  task automatic test_round();
    run_op(16'h0001, 16'h0080, 1'b0, 0, 1'b0);
    checks++;
    if (data_out_round !== 16'h0000) begin
      errors++;
      $display("FAIL round_trunc: got %h want 0000", data_out_round);
    end
    run_op(16'h0001, 16'h0080, 1'b1, 0, 1'b0);
    checks++;
    if (data_out_round !== 16'h0001) begin
      errors++;
      $display("FAIL round_half_up: got %h want 0001", data_out_round);
    end
  endtask

  task automatic test_overflow();
    run_op(16'h7FFF, 16'h7FFF, 1'b0, 0, 1'b0);
    checks++;
    if (ovf !== 1'b1 || data_out_round !== 16'h7FFF || ovf_w !== 1'b1 ||
        data_out_round_w !== 16'h7F00) begin
      errors++;
      $display("FAIL overflow: got sat %b/%h wrap %b/%h want 1/7fff 1/7f00",
               ovf, data_out_round, ovf_w, data_out_round_w);
    end
  endtask

  task automatic test_random();
    logic [DATA-1:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = DATA'($urandom);
      b = DATA'($urandom);
      if (i % 7 == 3) a[M-1:0] = '0;
      if (i % 5 == 1) b[M-1:0] = M'($urandom_range(0, 255));
      run_op(a, b, 1'($urandom), 0, 1'(i % 2));
    end
  endtask

  task automatic test_back_to_back();
    run_op(16'h0123, 16'h8456, 1'b1, 0, 1'b0);
    run_op(16'h7FFF, 16'h0100, 1'b0, 0, 1'b1);
    run_op(16'h4000, 16'h4000, 1'b1, 0, 1'b0);
  endtask

  task automatic test_handshake_reset();
    bit seen;
    run_op(16'h0180, 16'h0200, 1'b0, 5, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_exit: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    in_valid = 1'b1;
    data_in1 = 16'h7FFF;
    data_in2 = 16'h7FFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== '0 ||
        data_out_round !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy_reset: got rdy=%b v=%b %h %h %b want 1 0 0 0 0",
               in_ready, out_valid, data_out, data_out_round, ovf);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid || out_valid_w) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL aborted_op_valid: got pulse=%b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_round();
    test_overflow();
    test_back_to_back();
    test_random();
    test_handshake_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
